// File: rtl/tick_rate_detector.sv
// Recovers the speed setting of a rate-divider tick stream: measures tick-to-tick
// periods, classifies them against the four nominals and locks after MATCH_COUNT agreeing periods.
module tick_rate_detector #(
  parameter int divisor     = 1,
  parameter int TOL         = 4,
  parameter int MATCH_COUNT = 3,
  parameter int TIMEOUT     = 100000000 / divisor
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic        tick,
  output logic [1:0]  speedSelect,
  output logic        locked,
  output logic [26:0] period,
  output logic        lockPulse
);
  localparam int N1 = 12500000 / divisor;
  localparam int N2 = 25000000 / divisor;
  localparam int N3 = 50000000 / divisor;

  typedef enum logic [1:0] {S_IDLE, S_MEASURE, S_LOCKED} state_t;

  state_t      r_state, w_state;
  logic [26:0] r_cnt, w_cnt;
  logic [1:0]  r_cand, w_cand;
  logic [2:0]  r_mc, w_mc, w_mc_up;
  logic [1:0]  w_spd;
  logic        w_locked, w_lp;
  logic [26:0] w_per;
  logic [1:0]  w_cls;
  logic        w_cls_vld;

  function automatic logic near(input logic [26:0] p, input int n);
    int d;
    d = int'({5'd0, p}) - n;
    return (d <= TOL) && (d >= -TOL);
  endfunction

  // Classify the running count as the period of a tick arriving this cycle; lowest code wins on overlap.
  always_comb begin
    w_cls     = 2'd0;
    w_cls_vld = 1'b1;
    if (r_cnt == 27'd1)   w_cls = 2'd0;
    else if (near(r_cnt, N1)) w_cls = 2'd1;
    else if (near(r_cnt, N2)) w_cls = 2'd2;
    else if (near(r_cnt, N3)) w_cls = 2'd3;
    else w_cls_vld = 1'b0;
  end

  always_comb begin
    w_state  = r_state;
    w_cnt    = (r_cnt == '1) ? r_cnt : r_cnt + 27'd1;
    w_cand   = r_cand;
    w_mc     = r_mc;
    w_mc_up  = (w_cls == r_cand) ? r_mc + 3'd1 : 3'd1;
    w_spd    = speedSelect;
    w_locked = locked;
    w_per    = period;
    w_lp     = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cnt = '0;
        if (tick) begin
          w_state = S_MEASURE;
          w_cnt   = 27'd1;
        end
      end
      S_MEASURE: begin
        if (tick) begin
          w_cnt = 27'd1;
          w_per = r_cnt;
          if (w_cls_vld) begin
            w_cand = w_cls;
            w_mc   = w_mc_up;
            if (w_mc_up == 3'(MATCH_COUNT)) begin
              w_state  = S_LOCKED;
              w_spd    = w_cls;
              w_locked = 1'b1;
              w_lp     = 1'b1;
            end
          end else begin
            w_mc = '0;
          end
        end else if (r_cnt == 27'(TIMEOUT)) begin
          w_state  = S_IDLE;
          w_cnt    = '0;
          w_mc     = '0;
          w_locked = 1'b0;
        end
      end
      S_LOCKED: begin
        if (tick) begin
          w_cnt = 27'd1;
          w_per = r_cnt;
          if (!(w_cls_vld && w_cls == speedSelect)) begin
            w_state  = S_MEASURE;
            w_locked = 1'b0;
            w_mc     = '0;
            if (w_cls_vld) begin
              w_cand = w_cls;
              w_mc   = 3'd1;
            end
          end
        end else if (r_cnt == 27'(TIMEOUT)) begin
          w_state  = S_IDLE;
          w_cnt    = '0;
          w_mc     = '0;
          w_locked = 1'b0;
        end
      end
      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_cand      <= '0;
      r_mc        <= '0;
      speedSelect <= '0;
      locked      <= 1'b0;
      period      <= '0;
      lockPulse   <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_cnt       <= w_cnt;
      r_cand      <= w_cand;
      r_mc        <= w_mc;
      speedSelect <= w_spd;
      locked      <= w_locked;
      period      <= w_per;
      lockPulse   <= w_lp;
    end
  end
endmodule

// File: tb/tb_tick_rate_detector.sv
// Randomized scoreboard bench: a time-stamp based reference model predicts the outputs
// after every clock edge; a negedge monitor pops and compares.
module tb_tick_rate_detector;
  localparam int DIV = 100000;
  localparam int TOL = 4;
  localparam int MC  = 3;
  localparam int TO  = 1000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tick = 1'b0;
  logic [1:0]  speedSelect;
  logic        locked;
  logic [26:0] period;
  logic        lockPulse;

  tick_rate_detector #(.divisor(DIV), .TOL(TOL), .MATCH_COUNT(MC), .TIMEOUT(TO)) dut (
    .CLOCK_50(clk), .reset(rst_n), .tick(tick),
    .speedSelect(speedSelect), .locked(locked), .period(period), .lockPulse(lockPulse)
  );

  always #10 clk = ~clk;

  typedef struct {
    logic [1:0]  spd;
    logic        lk;
    logic [26:0] per;
    logic        lp;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  // Reference model: time stamps of ticks, not a counter.
  int now = 0;
  int last_t = 0;
  bit m_idle = 1;
  bit m_lk = 0;
  bit m_lp = 0;
  int m_cand = 0, m_mc = 0, m_spd = 0, m_per = 0;

  function automatic int classify(input int p);
    int nom[4];
    nom[1] = 12500000 / DIV; nom[2] = 25000000 / DIV; nom[3] = 50000000 / DIV;
    if (p == 1) return 0;
    for (int k = 1; k < 4; k++)
      if ((p - nom[k] <= TOL) && (nom[k] - p <= TOL)) return k;
    return -1;
  endfunction

  task automatic model_step(input bit t, input bit r);
    int el, c;
    m_lp = 0;
    if (!r) begin
      m_idle = 1; m_lk = 0; m_cand = 0; m_mc = 0; m_spd = 0; m_per = 0;
    end else if (m_idle) begin
      if (t) begin m_idle = 0; last_t = now; end
    end else begin
      el = now - last_t;
      if (t) begin
        m_per = el; last_t = now; c = classify(el);
        if (m_lk) begin
          if (c != m_spd) begin
            m_lk = 0;
            if (c >= 0) begin m_cand = c; m_mc = 1; end else m_mc = 0;
          end
        end else if (c >= 0) begin
          m_mc = (c == m_cand) ? m_mc + 1 : 1;
          m_cand = c;
          if (m_mc == MC) begin m_lk = 1; m_spd = c; m_lp = 1; end
        end else m_mc = 0;
      end else if (el == TO) begin
        m_idle = 1; m_lk = 0; m_mc = 0;
      end
    end
    now++;
  endtask

  task automatic cyc(input bit t, input bit r);
    exp_t e;
    @(negedge clk);
    tick = t; rst_n = r;
    model_step(t, r);
    e.spd = 2'(m_spd); e.lk = m_lk; e.per = 27'(m_per); e.lp = m_lp;
    @(posedge clk);
    q.push_back(e);
  endtask

  task automatic ticks(input int p, input int n);
    for (int i = 0; i < n; i++) begin
      for (int j = 1; j < p; j++) cyc(0, 1);
      cyc(1, 1);
    end
  endtask

  // Monitor: the DUT presents a fresh output set after every edge.
  int mon_cyc = 0;
  exp_t me;
  always @(negedge clk) begin
    mon_cyc++;
    if (q.size() > 0) begin
      me = q.pop_front();
      checks++;
      if (speedSelect !== me.spd || locked !== me.lk || period !== me.per || lockPulse !== me.lp) begin
        errors++;
        $display("FAIL outputs cyc %0d: got spd=%0d lk=%0b per=%0d lp=%0b, want spd=%0d lk=%0b per=%0d lp=%0b",
                 mon_cyc, speedSelect, locked, period, lockPulse, me.spd, me.lk, me.per, me.lp);
      end
    end
  end

  initial begin
    int code, n, p, nom[4];
    nom[0] = 1; nom[1] = 125; nom[2] = 250; nom[3] = 500;
    repeat (3) cyc(0, 0);
    // held-high tick locks to full speed
    repeat (8) cyc(1, 1);
    cyc(0, 1);
    // 2 Hz, then within-tolerance jitter
    ticks(250, 5);
    ticks(252, 3);
    for (int i = 0; i < 4; i++) ticks(250 + $urandom_range(0, 2 * TOL) - TOL, 1);
    // switch to 1 Hz
    ticks(500, 4);
    // period with no nominal from a fresh reset
    cyc(0, 0);
    ticks(200, 20);
    // 4 Hz lock, timeout, lone tick, and tick exactly on the timeout count
    cyc(0, 0);
    ticks(125, 5);
    repeat (1100) cyc(0, 1);
    ticks(125, 1);
    repeat (50) cyc(0, 1);
    ticks(125, 4);
    ticks(TO, 1);
    ticks(125, 4);
    ticks(TO + 1, 1);
    ticks(125, 2);
    // reset while locked at 1 Hz, then relock
    ticks(500, 4);
    cyc(0, 0);
    ticks(500, 4);
    // random segments of one code (4 = no nominal), with occasional gaps near the timeout
    for (int s = 0; s < 14; s++) begin
      code = $urandom_range(0, 4);
      n = $urandom_range(2, 5);
      for (int i = 0; i < n; i++) begin
        if (code == 0) p = 1;
        else if (code == 4) p = $urandom_range(2, 100);
        else p = nom[code] + $urandom_range(0, 2 * TOL) - TOL;
        ticks(p, 1);
      end
      if ($urandom_range(0, 4) == 0) ticks(TO - 1 + $urandom_range(0, 2), 1);
    end
    cyc(0, 1);
    @(negedge clk);
    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
